spi_sample_sequencer: RTL and testbench

- Control-and-capture stage wrapped around the SPI amplifier/ADC segment.
- Drives that segment's start pulse and amp/ADC select. Programs the amplifier gain once after enable, then triggers ADC conversions at a fixed sample rate.
- Captures each 8-bit result into a one-deep output buffer with a valid/ready handshake, for the downstream consumer (display/UART/filter).
- Flags lost samples and a hung SPI segment.

---
 rtl/spi_sample_sequencer_pkg.sv | 22 ++
 rtl/spi_sample_sequencer_if.sv | 32 +++
 rtl/spi_sample_sequencer_tick_gen.sv | 37 +++
 rtl/spi_sample_sequencer.sv | 175 +++++++++++++++++
 tb/tb_spi_sample_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sample_sequencer_pkg.sv
// Shared encodings and defaults for the SPI sample sequencer.
package spi_sample_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_AMP_START = 3'd1;
  localparam state_t ST_AMP_WAIT  = 3'd2;
  localparam state_t ST_WAIT_TICK = 3'd3;
  localparam state_t ST_ADC_START = 3'd4;
  localparam state_t ST_ADC_WAIT  = 3'd5;
  localparam state_t ST_ERROR     = 3'd6;

  // Value driven on amp_adc to select the transaction type.
  localparam logic AMP_SEL = 1'b1;
  localparam logic ADC_SEL = 1'b0;

  localparam int DEF_SAMPLE_DIV = 50000;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_DIV_W      = 16;

endpackage

// File: rtl/spi_sample_sequencer_if.sv
// Bus between the sequencer, the SPI amp/ADC segment and the sample consumer.
interface spi_sample_sequencer_if;
  import spi_sample_sequencer_pkg::*;

  // SPI segment side: spi_init is a one-cycle start pulse qualified by
  // amp_adc; init_done marks completion and adc_data is valid with it.
  logic       spi_init;
  logic       amp_adc;
  logic       init_done;
  logic [7:0] adc_data;

  // Consumer side: valid/ready. A transfer happens on every clock edge where
  // sample_valid and sample_ready are both high; while sample_valid is high,
  // sample does not change unless that same edge is a transfer.
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;

  // Current FSM state, exported for observation.
  state_t     dbg_state;

  modport master (
    output spi_init, amp_adc, sample, sample_valid, dbg_state,
    input  init_done, adc_data, sample_ready
  );

  modport slave (
    input  spi_init, amp_adc, sample, sample_valid, dbg_state,
    output init_done, adc_data, sample_ready
  );

endinterface

// File: rtl/spi_sample_sequencer_tick_gen.sv
// Loadable down-counter producing a conversion tick every SAMPLE_DIV cycles.
module sample_tick_gen
  import spi_sample_sequencer_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] count_q, count_d;

  assign tick_o = (count_q == '0);

  // Load on request; otherwise count down while enabled, reloading on tick.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = RELOAD;
    end else if (en_i) begin
      count_d = tick_o ? RELOAD : count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/spi_sample_sequencer.sv
// Sequences amp-gain programming and periodic ADC conversions, buffers results.
module spi_sample_sequencer
  import spi_sample_sequencer_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear_flags,
  spi_sample_sequencer_if.master        bus,
  output logic                          overrun,
  output logic                          timeout_err,
  output logic                          busy
);

  state_t           state_q, state_d;
  logic             tick, div_load, div_en;
  logic [DIV_W-1:0] wd_q, wd_d;
  logic             wd_expired;
  logic             tick_drop, cap_drop, timeout_hit, capture;
  logic [7:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             spi_init_c, amp_adc_c, busy_c;

  // The divider runs through the whole conversion so the start period is fixed.
  assign div_en = (state_q == ST_WAIT_TICK) || (state_q == ST_ADC_START) ||
                  (state_q == ST_ADC_WAIT);

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .DIV_W      (DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (div_load),
    .en_i   (div_en),
    .tick_o (tick)
  );

  assign wd_expired = (wd_q == DIV_W'(TIMEOUT - 1));
  assign capture    = (state_q == ST_ADC_WAIT) && bus.init_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, plus the tick-drop / timeout events tied to transitions.
  always_comb begin
    state_d     = state_q;
    div_load    = 1'b0;
    tick_drop   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      // A done level still high from before must not be taken as completion.
      ST_IDLE:      if (enable && !bus.init_done) state_d = ST_AMP_START;
      ST_AMP_START: state_d = ST_AMP_WAIT;
      // The SPI segment cannot abort, so a drop of enable only takes effect
      // once the running transaction has finished.
      ST_AMP_WAIT: begin
        if (bus.init_done) begin
          div_load = 1'b1;
          state_d  = enable ? ST_WAIT_TICK : ST_IDLE;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_ERROR;
        end
      end
      ST_WAIT_TICK: begin
        if (tick) begin
          if (!enable)            state_d   = ST_IDLE;
          else if (bus.init_done) tick_drop = 1'b1;
          else                    state_d   = ST_ADC_START;
        end
      end
      ST_ADC_START: begin
        tick_drop = tick;
        state_d   = ST_ADC_WAIT;
      end
      ST_ADC_WAIT: begin
        tick_drop = tick;
        if (bus.init_done) begin
          state_d = enable ? ST_WAIT_TICK : ST_IDLE;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_ERROR;
        end
      end
      ST_ERROR:     if (!enable) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    spi_init_c = 1'b0;
    amp_adc_c  = ADC_SEL;
    busy_c     = 1'b1;
    case (state_q)
      ST_IDLE:      busy_c = 1'b0;
      ST_AMP_START: begin spi_init_c = 1'b1; amp_adc_c = AMP_SEL; end
      ST_AMP_WAIT:  amp_adc_c = AMP_SEL;
      ST_ADC_START: spi_init_c = 1'b1;
      ST_ERROR:     busy_c = 1'b0;
      default:      ;
    endcase
  end

  // Watchdog counts wait cycles; every other state (START included) clears it.
  always_comb begin
    wd_d = '0;
    if ((state_q == ST_AMP_WAIT) || (state_q == ST_ADC_WAIT)) wd_d = wd_q + 1'b1;
  end

  // One-deep output buffer: a capture may replace a sample only if it is
  // being consumed on the same edge; otherwise the new result is lost.
  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    cap_drop = 1'b0;
    if (capture) begin
      if (!valid_q || bus.sample_ready) begin
        sample_d = bus.adc_data;
        valid_d  = 1'b1;
      end else begin
        cap_drop = 1'b1;
      end
    end else if (valid_q && bus.sample_ready) begin
      valid_d = 1'b0;
    end
  end

  // Sticky flags: a set event outranks a clear in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    if (tick_drop || cap_drop) overrun_d = 1'b1;
    else if (clear_flags)      overrun_d = 1'b0;
    if (timeout_hit)           timeout_d = 1'b1;
    else if (clear_flags)      timeout_d = 1'b0;
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.spi_init     = spi_init_c;
  assign bus.amp_adc      = amp_adc_c;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.dbg_state    = state_q;
  assign busy             = busy_c;
  assign overrun          = overrun_q;
  assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Bench for spi_sample_sequencer with a behavioural SPI segment model.
module tb_spi_sample_sequencer;
  import spi_sample_sequencer_pkg::*;

  localparam int SAMPLE_DIV = 20;
  localparam int TIMEOUT    = 64;
  localparam int DIV_W      = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clear_flags = 1'b0;
  logic overrun, timeout_err, busy;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_sample_sequencer_if bus ();

  spi_sample_sequencer #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .TIMEOUT    (TIMEOUT),
    .DIV_W      (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear_flags (clear_flags),
    .bus         (bus),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI segment model ----------------
  // Answers init_done model_delay cycles after spi_init (one-cycle pulse);
  // with model_mute set it never answers ADC transactions.
  int         model_delay = 10;
  bit         model_mute = 1'b0;
  logic [7:0] adc_src[$];
  int         mcnt = 0;
  logic [7:0] mcur = '0;
  bit         mcur_adc = 1'b0;

  // ---------------- scoreboard ----------------
  bit         sb_on = 1'b0;
  int         pops = 0;
  logic [7:0] exp_q[$];

  initial begin
    bus.init_done = 1'b0;
    bus.adc_data  = '0;
    forever begin
      @(negedge clk);
      bus.init_done = 1'b0;
      if (rst) begin
        mcnt = 0;
      end else begin
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            bus.init_done = 1'b1;
            bus.adc_data  = mcur;
            if (mcur_adc && sb_on) exp_q.push_back(mcur);
          end
        end
        if (bus.spi_init) begin
          mcur_adc = !bus.amp_adc;
          if (!mcur_adc)             mcur = 8'h00;
          else if (adc_src.size() > 0) mcur = adc_src.pop_front();
          else                       mcur = 8'($urandom_range(0, 255));
          if (!(model_mute && mcur_adc)) mcnt = model_delay;
        end
      end
    end
  end

  // Compare each consumed sample against the next expected value.
  always @(negedge clk) begin
    if (sb_on && !rst && bus.sample_valid && bus.sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_sample actual=%0h expected=none", bus.sample);
      end else begin
        check("sb_sample", {24'd0, bus.sample}, {24'd0, exp_q.pop_front()});
        pops++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start(input logic want_amp, input int budget, output int at_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.spi_init && (bus.amp_adc == want_amp)) && n < budget);
    check(want_amp ? "amp_start_seen" : "adc_start_seen",
          {31'd0, bus.spi_init && (bus.amp_adc == want_amp)}, 32'd1);
    at_cyc = cyc;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  // ---------------- capture-rule vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       ready_cap;      // sample_ready during the capture cycle
    logic       ready_post;     // sample_ready from the cycle after
    logic       clr_post;       // clear_flags pulse in the cycle after
    logic [7:0] exp_sample;
    logic       exp_valid;
    logic       exp_overrun;
    logic       exp_valid_post;
    logic       exp_overrun_post;
  } cap_vec_t;

  cap_vec_t vecs[5];

  initial begin
    int s_amp, s1, s2, s3, s, sa, sb, k;
    logic [13:0] outs;

    vecs[0] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0}; // empty: load
    vecs[1] = '{8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1}; // full, no ready: drop
    vecs[2] = '{8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0}; // load, then clear
    vecs[3] = '{8'h44, 1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0}; // handshake + capture
    vecs[4] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0}; // again, then consumed

    bus.sample_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    outs = {bus.spi_init, bus.amp_adc, bus.sample, bus.sample_valid, overrun, timeout_err, busy};
    check("reset_outputs", {18'd0, outs}, 32'd0);
    check("reset_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Amp programming, then a stream of three samples with ready held high.
    adc_src.push_back(8'hA5);
    adc_src.push_back(8'h3C);
    adc_src.push_back(8'h7E);
    sb_on = 1'b1;
    bus.sample_ready = 1'b1;
    enable = 1'b1;
    wait_start(1'b1, 10, s_amp);
    @(negedge clk);
    check("amp_pulse_one_cycle", {31'd0, bus.spi_init}, 32'd0);
    check("amp_sel_held", {31'd0, bus.amp_adc}, 32'd1);
    // done at s_amp+10; WAIT_TICK lasts SAMPLE_DIV cycles before ADC_START.
    wait_start(1'b0, 60, s1);
    check("first_adc_latency", s1 - s_amp, 32'(10 + 1 + SAMPLE_DIV));
    wait_start(1'b0, 40, s2);
    check("adc_period_1", s2 - s1, 32'(SAMPLE_DIV));
    wait_start(1'b0, 40, s3);
    check("adc_period_2", s3 - s2, 32'(SAMPLE_DIV));
    k = 0;
    while (pops < 3 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("sb_pop_count", pops, 32'd3);
    check("stream_overrun", {31'd0, overrun}, 32'd0);
    sb_on = 1'b0;

    // Capture rules, one vector per ADC conversion.
    for (int i = 0; i < 5; i++) begin
      adc_src.push_back(vecs[i].data);
      wait_start(1'b0, 40, s);
      repeat (10) @(negedge clk);
      bus.sample_ready = vecs[i].ready_cap;
      @(negedge clk);
      check($sformatf("vec%0d_sample", i), {24'd0, bus.sample}, {24'd0, vecs[i].exp_sample});
      check($sformatf("vec%0d_valid", i), {31'd0, bus.sample_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_overrun", i), {31'd0, overrun}, {31'd0, vecs[i].exp_overrun});
      bus.sample_ready = vecs[i].ready_post;
      clear_flags = vecs[i].clr_post;
      @(negedge clk);
      clear_flags = 1'b0;
      check($sformatf("vec%0d_sample_post", i), {24'd0, bus.sample}, {24'd0, vecs[i].exp_sample});
      check($sformatf("vec%0d_valid_post", i), {31'd0, bus.sample_valid}, {31'd0, vecs[i].exp_valid_post});
      check($sformatf("vec%0d_overrun_post", i), {31'd0, overrun}, {31'd0, vecs[i].exp_overrun_post});
    end

    // Unanswered ADC transaction: watchdog hits TIMEOUT-1 in the 64th wait
    // cycle, ERROR is visible the cycle after.
    model_mute = 1'b1;
    wait_start(1'b0, 40, s);
    k = 0;
    while (!timeout_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 32'(TIMEOUT + 1));
    check("error_state", {29'd0, bus.dbg_state}, {29'd0, ST_ERROR});
    check("error_busy", {31'd0, busy}, 32'd0);
    check("error_outputs", {30'd0, bus.spi_init, bus.amp_adc}, 32'd0);
    pulse_clear();
    check("timeout_cleared", {31'd0, timeout_err}, 32'd0);
    check("error_holds", {29'd0, bus.dbg_state}, {29'd0, ST_ERROR});
    enable = 1'b0;
    @(negedge clk);
    check("error_to_idle", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});

    // Re-enable reprograms the amp; slow model (25 > 20) drops one tick.
    model_mute = 1'b0;
    model_delay = 25;
    enable = 1'b1;
    wait_start(1'b1, 10, s);
    check("reenable_overrun_clear", {31'd0, overrun}, 32'd0);
    wait_start(1'b0, 80, sa);
    wait_start(1'b0, 80, sb);
    check("slow_adc_period", sb - sa, 32'(2 * SAMPLE_DIV));
    check("slow_overrun", {31'd0, overrun}, 32'd1);

    // Asynchronous reset in the middle of ADC_WAIT.
    repeat (5) @(negedge clk);
    check("pre_reset_state", {29'd0, bus.dbg_state}, {29'd0, ST_ADC_WAIT});
    #2 rst = 1'b1;
    #1;
    outs = {bus.spi_init, bus.amp_adc, bus.sample, bus.sample_valid, overrun, timeout_err, busy};
    check("async_reset_outputs", {18'd0, outs}, 32'd0);
    check("async_reset_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=%0d cycles expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
